mux_rr_arbiter: RTL

Round-robin arbiter and sequencer for the 4-to-1 multiplexer datapath. Four requesters share the mux. The block grants one requester at a time and drives the 2-bit select from the grant. It then registers the selected data lane as a qualified output stream. It sits directly in front of the mux and owns `sel`; no other logic drives the select.

---
 rtl/mux_rr_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter and sequencer for a shared 4-to-1 mux.
// Grants one of four requesters, drives the mux select from the grant and
// registers the selected lane as a qualified output stream.
// Optional feature: define MUX_ARB_BURST_LIMIT_EN to rotate the grant after
// BURST_MAX consecutive cycles whenever another requester is waiting.
module mux_rr_arbiter #(
    parameter int DATA_W    = 1,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [4*DATA_W-1:0] in,
    output logic [3:0]          gnt,
    output logic [1:0]          sel,
    output logic [DATA_W-1:0]   out,
    output logic                out_valid,
    output logic                busy
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;

    // Requests eligible for a new grant: the current owner is excluded so it
    // is only ever reconsidered after everyone else (it is searched last).
    logic [3:0] cand;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic       hand_off;
    logic       burst_hit;

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

    logic [7:0] burst_cnt_q, burst_cnt_d;

    assign burst_hit = (burst_cnt_q == BURST_LAST);
`else
    assign burst_hit = 1'b0;
`endif

    // BURST_MAX must fit the 8-bit burst counter.
    a_burst_max_range : assert property (@(posedge clk) (BURST_MAX >= 2) && (BURST_MAX <= 255));

    assign cand = req & ~gnt_q;

    // Round-robin search: first candidate at ptr_q, ptr_q+1, ptr_q+2, ptr_q+3 (mod 4).
    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!pick_found && cand[ptr_q + 2'(k)]) begin
                pick_found = 1'b1;
                pick_idx   = ptr_q + 2'(k);
            end
        end
    end

    // Next state: first grant, hold, hand-off on release/burst limit, or IDLE.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        hand_off = 1'b0;
`ifdef MUX_ARB_BURST_LIMIT_EN
        burst_cnt_d = burst_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                hand_off = (req != 4'b0000);
            end
            S_GRANT: begin
                // sel_q identifies the current owner while in GRANT.
                if (!req[sel_q] || (burst_hit && (cand != 4'b0000))) begin
                    hand_off = 1'b1;
                end else begin
`ifdef MUX_ARB_BURST_LIMIT_EN
                    // Limit reached with nobody waiting: keep the grant, restart the count.
                    burst_cnt_d = burst_hit ? 8'd0 : burst_cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (hand_off) begin
            if (pick_found) begin
                state_d = S_GRANT;
                gnt_d   = 4'b0001 << pick_idx;
                sel_d   = pick_idx;
                ptr_d   = pick_idx + 2'd1;
`ifdef MUX_ARB_BURST_LIMIT_EN
                burst_cnt_d = 8'd0;
`endif
            end else begin
                // No one left: drop the grant, select keeps pointing at the last owner.
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end
        end
    end

    // Data path: forward the selected lane only while a grant was active before the edge.
    always_comb begin
        out_d       = '0;
        out_valid_d = 1'b0;
        if (state_q == S_GRANT) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (sel_q == 2'(i)) begin
                    out_d = in[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // State and output registers; reset clears everything, including the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= 4'b0000;
            sel_q       <= 2'd0;
            ptr_q       <= 2'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef MUX_ARB_BURST_LIMIT_EN
            burst_cnt_q <= 8'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef MUX_ARB_BURST_LIMIT_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (gnt_q != 4'b0000);

endmodule
